i2s_tx_ctrl: RTL

I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

---
 rtl/i2s_tx_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: buffers stereo samples and presents one {left,right} pair per
// I2S frame to a transmitter, tracking frame boundaries from the fed-back
// word-select line. An empty buffer at a frame boundary while running
// produces silent frames and counts underruns.
//
// Ports:
//   sclk          - only clock, rising edge
//   rst           - synchronous active-high reset
//   enable        - run request; low flushes the buffer and silences outputs
//   cfg_prescaler - requested sclk cycles per channel (clamped to 2..AUDIO_DW)
//   s_valid/s_ready, s_left/s_right - sample input handshake
//   lrclk         - word select from the transmitter (0 = left, 1 = right)
//   prescaler     - prescaler driven to the transmitter
//   left_chan/right_chan - words presented to the transmitter
//   underrun      - one-cycle pulse per underrun frame
//   underrun_cnt  - saturating underrun count (cleared only by rst)
//   fifo_level    - current buffer occupancy
module i2s_tx_ctrl #(
  parameter int AUDIO_DW   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sclk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [AUDIO_DW-1:0]         cfg_prescaler,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [AUDIO_DW-1:0]         s_left,
  input  logic [AUDIO_DW-1:0]         s_right,
  input  logic                        lrclk,
  output logic [AUDIO_DW-1:0]         prescaler,
  output logic [AUDIO_DW-1:0]         left_chan,
  output logic [AUDIO_DW-1:0]         right_chan,
  output logic                        underrun,
  output logic [15:0]                 underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {DISABLED, WAIT, RUN, UNDERRUN} state_t;

  state_t                  state, state_next;
  logic                    lrclk_q;
  logic                    frame_start;
  logic [2*AUDIO_DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             level;
  logic                    wr, pop, zero_out, und_next;
  logic [AUDIO_DW-1:0]     pres_clamped;

  // Right-to-left word-select transition marks the start of a new frame.
  assign frame_start = lrclk_q & ~lrclk;
  assign fifo_level  = level;
  assign s_ready     = enable && (level < (AW+1)'(FIFO_DEPTH)) && (state != DISABLED);
  assign wr          = s_valid & s_ready;

  always_comb begin
    if (cfg_prescaler < AUDIO_DW'(2))
      pres_clamped = AUDIO_DW'(2);
    else if (cfg_prescaler > AUDIO_DW'(AUDIO_DW))
      pres_clamped = AUDIO_DW'(AUDIO_DW);
    else
      pres_clamped = cfg_prescaler;
  end

  // Pop decisions use the registered level, so a sample written into an
  // empty buffer on the same cycle as frame_start is never popped by it.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    zero_out   = 1'b0;
    und_next   = 1'b0;
    if (!enable) begin
      state_next = DISABLED;
      zero_out   = 1'b1;
    end else begin
      case (state)
        DISABLED: state_next = WAIT;
        WAIT: begin
          if (frame_start && level != '0) begin
            pop        = 1'b1;
            state_next = RUN;
          end
        end
        RUN: begin
          if (frame_start) begin
            if (level != '0) begin
              pop = 1'b1;
            end else begin
              zero_out   = 1'b1;
              und_next   = 1'b1;
              state_next = UNDERRUN;
            end
          end
        end
        UNDERRUN: begin
          if (frame_start) begin
            if (level != '0) begin
              pop        = 1'b1;
              state_next = RUN;
            end else begin
              zero_out = 1'b1;
              und_next = 1'b1;
            end
          end
        end
        default: state_next = DISABLED;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (wr) mem[wr_ptr] <= {s_left, s_right};
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state        <= DISABLED;
      lrclk_q      <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      left_chan    <= '0;
      right_chan   <= '0;
      prescaler    <= AUDIO_DW'(AUDIO_DW);
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state    <= state_next;
      lrclk_q  <= lrclk;
      underrun <= und_next;
      if (und_next && underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + 16'd1;
      if (state == DISABLED || frame_start)
        prescaler <= pres_clamped;
      if (pop) begin
        {left_chan, right_chan} <= mem[rd_ptr];
      end else if (zero_out) begin
        left_chan  <= '0;
        right_chan <= '0;
      end
      if (!enable) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr)  wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({wr, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

endmodule
